// File: rtl/issue_rs.sv
// Reservation station for one functional unit: captures renamed uops, wakes sources on writeback, issues one ready uop per cycle.
// Optional NCPU_RS_AGE_SELECT_EN: oldest-first select via an age matrix; otherwise the lowest-index ready entry wins.
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

module issue_rs #(
    parameter int CONFIG_P_RS_DEPTH = 2,
    parameter int PAYLOAD_W         = 64,
    parameter int WRITEBACK_WIDTH   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  push,
    output logic                                  push_ready,
    input  logic [PAYLOAD_W-1:0]                  push_payload,
    input  logic [`NCPU_PRF_AW-1:0]               push_prs1,
    input  logic                                  push_prs1_re,
    input  logic [`NCPU_PRF_AW-1:0]               push_prs2,
    input  logic                                  push_prs2_re,
    input  logic [(1<<`NCPU_PRF_AW)-1:0]          busytable,
    input  logic [WRITEBACK_WIDTH*`NCPU_PRF_AW-1:0] wb_prd,
    input  logic [WRITEBACK_WIDTH-1:0]            wb_prd_we,
    output logic                                  iss_valid,
    input  logic                                  iss_ready,
    output logic [PAYLOAD_W-1:0]                  iss_payload,
    output logic [`NCPU_PRF_AW-1:0]               iss_prs1,
    output logic [`NCPU_PRF_AW-1:0]               iss_prs2,
    output logic [CONFIG_P_RS_DEPTH:0]            rs_count
);
    localparam int DEPTH = 1 << CONFIG_P_RS_DEPTH;
    localparam int AW    = `NCPU_PRF_AW;
    localparam int IDX_W = CONFIG_P_RS_DEPTH;
    localparam int CNT_W = CONFIG_P_RS_DEPTH + 1;

    typedef logic [AW-1:0] pr_t;

    logic [DEPTH-1:0]     r_vld, r_rdy1, r_rdy2;
    pr_t                  r_prs1    [DEPTH];
    pr_t                  r_prs2    [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [CNT_W-1:0]     r_count;

    logic [DEPTH-1:0] w_cand;
    logic [IDX_W-1:0] w_free, w_sel;
    logic             w_push_fire, w_iss_fire, w_push_rdy1, w_push_rdy2;

    function automatic logic wb_hit(input pr_t prs);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WRITEBACK_WIDTH; k++)
            if (wb_prd_we[k] && wb_prd[k*AW +: AW] == prs) hit = 1'b1;
        return hit;
    endfunction

    assign push_ready  = (r_count != CNT_W'(DEPTH));
    assign rs_count    = r_count;
    assign w_cand      = r_vld & r_rdy1 & r_rdy2;
    assign iss_valid   = |w_cand;
    assign iss_payload = r_payload[w_sel];
    assign iss_prs1    = r_prs1[w_sel];
    assign iss_prs2    = r_prs2[w_sel];
    assign w_push_fire = push & push_ready & ~flush;
    assign w_iss_fire  = iss_valid & iss_ready & ~flush;
    // Writeback in the push cycle must count, since the busytable only reflects it a cycle later.
    assign w_push_rdy1 = ~push_prs1_re | ~busytable[push_prs1] | wb_hit(push_prs1);
    assign w_push_rdy2 = ~push_prs2_re | ~busytable[push_prs2] | wb_hit(push_prs2);

    always_comb begin
        w_free = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (!r_vld[i]) w_free = IDX_W'(i);
    end

`ifdef NCPU_RS_AGE_SELECT_EN
    // r_age[r][c] = 1 means entry r is older than entry c.
    logic [DEPTH-1:0] r_age [DEPTH];
    logic [DEPTH-1:0] w_has_older;

    always_comb begin
        w_has_older = '0;
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++)
                if (w_cand[j] && r_age[j][i]) w_has_older[i] = 1'b1;
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++)
            if (w_cand[i] && !w_has_older[i]) w_sel = IDX_W'(i);
    end

    always_ff @(posedge clk) begin
        if (w_push_fire) begin
            for (int r = 0; r < DEPTH; r++)
                for (int c = 0; c < DEPTH; c++)
                    if (IDX_W'(r) == w_free)      r_age[r][c] <= 1'b0;
                    else if (IDX_W'(c) == w_free) r_age[r][c] <= 1'b1;
        end
    end
`else
    always_comb begin
        w_sel = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (w_cand[i]) w_sel = IDX_W'(i);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_vld   <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i] && wb_hit(r_prs1[i])) r_rdy1[i] <= 1'b1;
                if (r_vld[i] && wb_hit(r_prs2[i])) r_rdy2[i] <= 1'b1;
                if (w_iss_fire && w_sel == IDX_W'(i)) r_vld[i] <= 1'b0;
                // The free slot is never the issuing one, so a freed entry is not reused this cycle.
                if (w_push_fire && w_free == IDX_W'(i)) begin
                    r_vld[i]  <= 1'b1;
                    r_rdy1[i] <= w_push_rdy1;
                    r_rdy2[i] <= w_push_rdy2;
                end
            end
            if (w_push_fire && !w_iss_fire)      r_count <= r_count + 1'b1;
            else if (!w_push_fire && w_iss_fire) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_fire) begin
            r_prs1[w_free]    <= push_prs1;
            r_prs2[w_free]    <= push_prs2;
            r_payload[w_free] <= push_payload;
        end
    end
endmodule
